// File: rtl/mining_link_ctrl_if.sv
// UART-side byte handshake bundle for the mining link sequencer.
// master = sequencer, slave = UART receiver/transmitter side.
interface mining_link_ctrl_if;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic       tx_active;
   logic       tx_done;
   logic       tx_dv;
   logic [7:0] tx_byte;

   modport master (
      input  rx_dv, rx_byte, tx_active, tx_done,
      output tx_dv, tx_byte
   );

   modport slave (
      output rx_dv, rx_byte, tx_active, tx_done,
      input  tx_dv, tx_byte
   );
endinterface

// File: rtl/mining_link_ctrl.sv
// Mining link sequencer: header assembly, timed hash run,
// best-hash/nonce readback over the UART transmitter.
module mining_link_ctrl #(
   parameter int BLOCK_BYTES     = 76,
   parameter int HASH_SECONDS    = 1,
   parameter int RX_TIMEOUT_CLKS = 2_000_000
) (
   input  logic                     clk,
   input  logic                     rst_i,
   mining_link_ctrl_if.master       uart,
   input  logic                     second_tick,
   input  logic [255:0]             best_hash,
   input  logic [31:0]              best_hash_nonce,
   output logic                     hash_enable,
   output logic                     core_clear,
   output logic [8*BLOCK_BYTES-1:0] block_info,
   output logic [2:0]               state,
   output logic [6:0]               bytes_rcvd,
   output logic                     frame_err
);
   localparam int IW = $clog2(RX_TIMEOUT_CLKS + 1);
   localparam int TW = $clog2(HASH_SECONDS + 1);

   typedef enum logic [2:0] {
      S_RECV  = 3'd1,
      S_CLEAR = 3'd2,
      S_HASH  = 3'd3,
      S_LATCH = 3'd4,
      S_SEND  = 3'd5,
      S_WAIT  = 3'd6
   } state_e;

   state_e                   state_q, state_d;
   logic [IW-1:0]            idle_q, idle_d;
   logic [TW-1:0]            tick_q, tick_d;
   logic [287:0]             send_q, send_d;
   logic [5:0]               cnt_q, cnt_d;
   logic [6:0]               bytes_q, bytes_d;
   logic [7:0]               tx_byte_q, tx_byte_d;
   logic                     tx_dv_q, tx_dv_d;
   logic                     hash_en_q, hash_en_d;
   logic                     clear_q, clear_d;
   logic                     ferr_q, ferr_d;
   logic                     accept;
   logic [8*BLOCK_BYTES-1:0] block_q;

   always_comb begin
      state_d   = state_q;
      idle_d    = idle_q;
      tick_d    = tick_q;
      send_d    = send_q;
      cnt_d     = cnt_q;
      bytes_d   = bytes_q;
      tx_byte_d = tx_byte_q;
      tx_dv_d   = 1'b0;
      ferr_d    = 1'b0;
      accept    = 1'b0;
      case (state_q)
         S_RECV: begin
            // a byte arriving on the expiry cycle wins over the timeout
            if (uart.rx_dv) begin
               accept = 1'b1;
               idle_d = '0;
               if (bytes_q == 7'(BLOCK_BYTES - 1)) begin
                  bytes_d = '0;
                  state_d = S_CLEAR;
               end else begin
                  bytes_d = bytes_q + 7'd1;
               end
            end else if (bytes_q != '0) begin
               idle_d = idle_q + 1'b1;
               if (idle_d == IW'(RX_TIMEOUT_CLKS)) begin
                  idle_d  = '0;
                  bytes_d = '0;
                  ferr_d  = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            tick_d  = '0;
            state_d = S_HASH;
         end
         S_HASH: begin
            if (second_tick) begin
               tick_d = tick_q + 1'b1;
               if (tick_d == TW'(HASH_SECONDS)) state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            send_d = {best_hash_nonce, best_hash};
            cnt_d  = 6'd36;
            // issue the first byte straight away when the line is idle
            if (!uart.tx_active) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = best_hash[7:0];
               state_d   = S_WAIT;
            end else begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (!uart.tx_active) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = send_q[7:0];
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (uart.tx_done) begin
               send_d  = send_q >> 8;
               cnt_d   = cnt_q - 6'd1;
               state_d = (cnt_d == '0) ? S_RECV : S_SEND;
            end
         end
         default: state_d = S_RECV;
      endcase
   end

   assign hash_en_d = (state_d == S_HASH);
   assign clear_d   = (state_d == S_CLEAR);

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_RECV;
         idle_q    <= '0;
         tick_q    <= '0;
         send_q    <= '0;
         cnt_q     <= '0;
         bytes_q   <= '0;
         tx_byte_q <= '0;
         tx_dv_q   <= 1'b0;
         hash_en_q <= 1'b0;
         clear_q   <= 1'b0;
         ferr_q    <= 1'b0;
         block_q   <= '0;
      end else begin
         state_q   <= state_d;
         idle_q    <= idle_d;
         tick_q    <= tick_d;
         send_q    <= send_d;
         cnt_q     <= cnt_d;
         bytes_q   <= bytes_d;
         tx_byte_q <= tx_byte_d;
         tx_dv_q   <= tx_dv_d;
         hash_en_q <= hash_en_d;
         clear_q   <= clear_d;
         ferr_q    <= ferr_d;
         if (accept) block_q[{bytes_q, 3'b000} +: 8] <= uart.rx_byte;
      end
   end

   assign uart.tx_dv   = tx_dv_q;
   assign uart.tx_byte = tx_byte_q;
   assign hash_enable  = hash_en_q;
   assign core_clear   = clear_q;
   assign block_info   = block_q;
   assign state        = state_q;
   assign bytes_rcvd   = bytes_q;
   assign frame_err    = ferr_q;
endmodule

// File: tb/tb_mining_link_ctrl.sv
// Directed testbench for mining_link_ctrl.
module tb_mining_link_ctrl;
   localparam int BB = 76;
   localparam int HS = 2;
   localparam int T  = 300;

   logic            clk;
   logic            rst_i;
   logic            second_tick;
   logic [255:0]    best_hash;
   logic [31:0]     best_hash_nonce;
   logic            hash_enable;
   logic            core_clear;
   logic [8*BB-1:0] block_info;
   logic [2:0]      state;
   logic [6:0]      bytes_rcvd;
   logic            frame_err;

   mining_link_ctrl_if u_if ();

   mining_link_ctrl #(
      .BLOCK_BYTES(BB),
      .HASH_SECONDS(HS),
      .RX_TIMEOUT_CLKS(T)
   ) dut (
      .clk(clk),
      .rst_i(rst_i),
      .uart(u_if),
      .second_tick(second_tick),
      .best_hash(best_hash),
      .best_hash_nonce(best_hash_nonce),
      .hash_enable(hash_enable),
      .core_clear(core_clear),
      .block_info(block_info),
      .state(state),
      .bytes_rcvd(bytes_rcvd),
      .frame_err(frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [639:0] obs,
                      input logic [639:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      u_if.rx_dv   = 1'b1;
      u_if.rx_byte = b;
      tick();
      u_if.rx_dv   = 1'b0;
   endtask

   logic [8*BB-1:0] expb;
   logic [255:0]    hash_a;
   logic [7:0]      exp_tx [36];
   int              n;
   int              cnt;

   initial begin
      rst_i           = 1'b0;
      u_if.rx_dv      = 1'b0;
      u_if.rx_byte    = 8'h00;
      u_if.tx_active  = 1'b0;
      u_if.tx_done    = 1'b0;
      second_tick     = 1'b0;
      best_hash       = '0;
      best_hash_nonce = '0;
      tick();
      tick();
      chk("rst_state", state, 3'd1);
      chk("rst_tx_dv", u_if.tx_dv, 1'b0);
      chk("rst_tx_byte", u_if.tx_byte, 8'h00);
      chk("rst_hash_en", hash_enable, 1'b0);
      chk("rst_clear", core_clear, 1'b0);
      chk("rst_block", block_info, '0);
      chk("rst_bytes", bytes_rcvd, 7'd0);
      chk("rst_ferr", frame_err, 1'b0);
      rst_i = 1'b1;
      tick();

      // frame 1: bytes 0x00..0x4B
      for (int i = 0; i < BB; i++) begin
         send_byte(8'(i));
         expb[8*i +: 8] = 8'(i);
         if (i == 39) chk("f1_bytes40", bytes_rcvd, 7'd40);
      end
      chk("f1_state_clear", state, 3'd2);
      chk("f1_clear_pulse", core_clear, 1'b1);
      chk("f1_bytes0", bytes_rcvd, 7'd0);
      chk("f1_blk_lo", block_info[7:0], 8'h00);
      chk("f1_blk_hi", block_info[607:600], 8'h4B);
      chk("f1_blk_all", block_info, expb);
      chk("f1_hash_en_lag", hash_enable, 1'b0);
      tick();
      chk("f1_state_hash", state, 3'd3);
      chk("f1_clear_gone", core_clear, 1'b0);
      chk("f1_hash_en", hash_enable, 1'b1);

      for (int i = 0; i < 32; i++) begin
         hash_a[8*i +: 8] = 8'(i);
         exp_tx[i] = 8'(i);
      end
      exp_tx[32] = 8'hEF;
      exp_tx[33] = 8'hBE;
      exp_tx[34] = 8'hAD;
      exp_tx[35] = 8'hDE;
      best_hash       = hash_a;
      best_hash_nonce = 32'hDEADBEEF;

      repeat (98) tick();
      second_tick = 1'b1;
      tick();
      second_tick = 1'b0;
      chk("h1_still_hash", state, 3'd3);
      chk("h1_still_en", hash_enable, 1'b1);
      repeat (199) tick();
      second_tick = 1'b1;
      tick();
      second_tick = 1'b0;
      chk("h2_latch", state, 3'd4);
      chk("h2_en_off", hash_enable, 1'b0);
      chk("h2_no_dv", u_if.tx_dv, 1'b0);
      tick();
      best_hash       = '1;
      best_hash_nonce = 32'h0;
      chk("tx_first_dv", u_if.tx_dv, 1'b1);
      chk("tx_first_state", state, 3'd6);

      for (int i = 0; i < 36; i++) begin
         if (i > 0) begin
            chk("tx_send_state", state, 3'd5);
            chk("tx_gap_dv", u_if.tx_dv, 1'b0);
            n = 0;
            while (u_if.tx_dv !== 1'b1 && n < 20) begin
               tick();
               n++;
            end
            chk("tx_dv_seen", u_if.tx_dv, 1'b1);
         end
         chk($sformatf("tx_byte%0d", i), u_if.tx_byte, exp_tx[i]);
         repeat (9) tick();
         chk($sformatf("tx_hold%0d", i), u_if.tx_byte, exp_tx[i]);
         u_if.tx_done = 1'b1;
         tick();
         u_if.tx_done = 1'b0;
      end
      chk("tx_back_recv", state, 3'd1);
      tick();
      chk("tx_no_extra", u_if.tx_dv, 1'b0);

      // timeout boundary: byte on the expiry cycle wins
      send_byte(8'h11);
      repeat (T - 1) tick();
      send_byte(8'h22);
      chk("to_tie_ferr", frame_err, 1'b0);
      chk("to_tie_bytes", bytes_rcvd, 7'd2);
      repeat (T - 1) tick();
      chk("to_pre_ferr", frame_err, 1'b0);
      chk("to_pre_bytes", bytes_rcvd, 7'd2);
      tick();
      chk("to_ferr", frame_err, 1'b1);
      chk("to_bytes0", bytes_rcvd, 7'd0);
      tick();
      chk("to_ferr_pulse", frame_err, 1'b0);

      for (int i = 0; i < 40; i++) send_byte(8'(8'h40 + i));
      chk("to40_bytes", bytes_rcvd, 7'd40);
      cnt = 0;
      repeat (T + 20) begin
         tick();
         if (frame_err === 1'b1) cnt++;
      end
      chk("to40_ferr_once", cnt, 1);
      chk("to40_bytes0", bytes_rcvd, 7'd0);
      chk("to40_state", state, 3'd1);

      for (int i = 0; i < BB; i++) begin
         expb[8*i +: 8] = 8'(i * 3 + 7);
         send_byte(8'(i * 3 + 7));
      end
      chk("f2_state_clear", state, 3'd2);
      chk("f2_blk_all", block_info, expb);
      tick();
      chk("f2_state_hash", state, 3'd3);

      // run 2: transmitter busy through SEND
      send_byte(8'h99);
      chk("f2_hash_rx_ign", bytes_rcvd, 7'd0);
      for (int i = 0; i < 32; i++) best_hash[8*i +: 8] = 8'(8'h80 + i);
      best_hash_nonce = 32'h01234567;
      u_if.tx_active  = 1'b1;
      second_tick = 1'b1;
      tick();
      second_tick = 1'b0;
      tick();
      second_tick = 1'b1;
      tick();
      second_tick = 1'b0;
      chk("f2_latch", state, 3'd4);
      tick();
      chk("f2_send", state, 3'd5);
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         u_if.rx_dv   = (i % 10 == 3);
         u_if.rx_byte = 8'h5A;
         tick();
         if (u_if.tx_dv === 1'b1) cnt++;
      end
      u_if.rx_dv = 1'b0;
      chk("busy_no_dv", cnt, 0);
      chk("busy_bytes0", bytes_rcvd, 7'd0);
      chk("busy_state", state, 3'd5);
      u_if.tx_active = 1'b0;
      tick();
      chk("busy_dv", u_if.tx_dv, 1'b1);
      chk("busy_byte", u_if.tx_byte, 8'h80);
      chk("busy_wait", state, 3'd6);
      tick();

      // asynchronous reset inside WAIT_TX
      rst_i = 1'b0;
      #1;
      chk("ar_state", state, 3'd1);
      chk("ar_tx_dv", u_if.tx_dv, 1'b0);
      chk("ar_tx_byte", u_if.tx_byte, 8'h00);
      chk("ar_hash_en", hash_enable, 1'b0);
      chk("ar_clear", core_clear, 1'b0);
      chk("ar_block", block_info, '0);
      chk("ar_bytes", bytes_rcvd, 7'd0);
      chk("ar_ferr", frame_err, 1'b0);
      tick();
      rst_i = 1'b1;
      u_if.tx_done = 1'b1;
      tick();
      u_if.tx_done = 1'b0;
      chk("late_done_state", state, 3'd1);
      chk("late_done_byte", u_if.tx_byte, 8'h00);
      cnt = 0;
      repeat (5) begin
         tick();
         if (u_if.tx_dv === 1'b1) cnt++;
      end
      chk("late_done_no_dv", cnt, 0);
      second_tick = 1'b1;
      tick();
      second_tick = 1'b0;
      chk("tick_in_recv", state, 3'd1);
      chk("tick_no_en", hash_enable, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
